// File: rtl/hazard_ctl.sv
// hazard_ctl: pipeline sequencing controller for the five-stage core.
// Drives the write enables and bubble flushes of the PC and the IF/ID, ID/EX,
// EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch
// redirects, data-memory stalls and an orderly drain after a halt.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   i_id_rX/_used, i_id_rY/_used  source registers of the ID instruction
//   i_id_halt                  ID instruction is halt
//   i_ex_rO, i_ex_dmem_ren     destination register / load flag of EX
//   i_ex_redirect              taken branch or jump resolved in EX
//   i_dmem_req, i_dmem_ready   MEM-stage data memory handshake
//   o_*_wen, o_*_flush         pipeline register controls (combinational)
//   o_halted, o_state          drain status (registered)
//   o_stall_cycles, o_bubble_count  performance counters
//
// Optional feature macro: HAZARD_PERF_EN builds the performance counters;
// without it both counter ports are tied to zero.
module hazard_ctl #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  i_id_rX,
    input  logic        i_id_rX_used,
    input  logic [2:0]  i_id_rY,
    input  logic        i_id_rY_used,
    input  logic        i_id_halt,
    input  logic [2:0]  i_ex_rO,
    input  logic        i_ex_dmem_ren,
    input  logic        i_ex_redirect,
    input  logic        i_dmem_req,
    input  logic        i_dmem_ready,
    output logic        o_pc_wen,
    output logic        o_ifid_wen,
    output logic        o_ifid_flush,
    output logic        o_idex_wen,
    output logic        o_idex_flush,
    output logic        o_exmem_wen,
    output logic        o_memwb_wen,
    output logic        o_halted,
    output logic [1:0]  o_state,
    output logic [15:0] o_stall_cycles,
    output logic [15:0] o_bubble_count
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned PERF_W = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mstall;
    logic               luse;

    assign mstall = i_dmem_req & ~i_dmem_ready;
    assign luse   = i_ex_dmem_ren &
                    ((i_id_rX_used & (i_id_rX == i_ex_rO)) |
                     (i_id_rY_used & (i_id_rY == i_ex_rO)));

    // State and drain counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and same-cycle pipeline controls
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        o_pc_wen     = 1'b1;
        o_ifid_wen   = 1'b1;
        o_ifid_flush = 1'b0;
        o_idex_wen   = 1'b1;
        o_idex_flush = 1'b0;
        o_exmem_wen  = 1'b1;
        o_memwb_wen  = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (mstall) begin
                    o_pc_wen    = 1'b0;
                    o_ifid_wen  = 1'b0;
                    o_idex_wen  = 1'b0;
                    o_exmem_wen = 1'b0;
                    o_memwb_wen = 1'b0;
                end else if (i_ex_redirect) begin
                    // Squashes whatever sits in IF and ID, halt included
                    o_ifid_flush = 1'b1;
                    o_idex_flush = 1'b1;
                end else if (luse) begin
                    o_pc_wen     = 1'b0;
                    o_ifid_wen   = 1'b0;
                    o_idex_flush = 1'b1;
                end else if (i_id_halt) begin
                    // Halt moves on to EX; nothing new is fetched behind it
                    o_pc_wen     = 1'b0;
                    o_ifid_flush = 1'b1;
                    state_d      = ST_DRAIN;
                    cnt_d        = CNT_W'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                o_pc_wen     = 1'b0;
                o_ifid_flush = 1'b1;
                o_idex_flush = 1'b1;
                if (mstall) begin
                    o_ifid_wen  = 1'b0;
                    o_idex_wen  = 1'b0;
                    o_exmem_wen = 1'b0;
                    o_memwb_wen = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            default: begin
                // HALTED is terminal until reset
                o_pc_wen    = 1'b0;
                o_ifid_wen  = 1'b0;
                o_idex_wen  = 1'b0;
                o_exmem_wen = 1'b0;
                o_memwb_wen = 1'b0;
            end
        endcase
    end

    assign o_state  = state_q;
    assign o_halted = (state_q == ST_HALTED);

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_q, stall_d;
    logic [PERF_W-1:0] bubble_q, bubble_d;

    // Saturating stall and bubble counters
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if ((state_q == ST_RUN || state_q == ST_DRAIN) && !o_pc_wen &&
            stall_q != {PERF_W{1'b1}}) begin
            stall_d = stall_q + PERF_W'(1);
        end
        if (o_idex_flush && o_idex_wen && bubble_q != {PERF_W{1'b1}}) begin
            bubble_d = bubble_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign o_stall_cycles = stall_q;
    assign o_bubble_count = bubble_q;
`else
    assign o_stall_cycles = 16'h0000;
    assign o_bubble_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// tb_hazard_ctl: directed vectors for hazard_ctl. Each vector pushes its
// hand-computed expectation into a queue; a negedge monitor pops and compares.
module tb_hazard_ctl;

    typedef struct packed {
        logic [2:0] rx;
        logic       rxu;
        logic [2:0] ry;
        logic       ryu;
        logic       halt;
        logic [2:0] exro;
        logic       ren;
        logic       redir;
        logic       dreq;
        logic       drdy;
        logic       rst;
    } stim_t;

    typedef struct packed {
        logic        chk;
        logic        chk_fl;
        logic        chk_perf;
        logic [4:0]  wen;    // pc, ifid, idex, exmem, memwb
        logic [1:0]  fl;     // ifid, idex
        logic [1:0]  st;
        logic        h;
        logic [15:0] sc;
        logic [15:0] bc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  i_id_rX, i_id_rY, i_ex_rO;
    logic        i_id_rX_used, i_id_rY_used, i_id_halt;
    logic        i_ex_dmem_ren, i_ex_redirect, i_dmem_req, i_dmem_ready;
    logic        o_pc_wen, o_ifid_wen, o_ifid_flush, o_idex_wen, o_idex_flush;
    logic        o_exmem_wen, o_memwb_wen, o_halted;
    logic [1:0]  o_state;
    logic [15:0] o_stall_cycles, o_bubble_count;

    int errors = 0;
    int checks = 0;
    exp_t  exp_q[$];
    string name_q[$];

    hazard_ctl #(.DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst(rst),
        .i_id_rX(i_id_rX), .i_id_rX_used(i_id_rX_used),
        .i_id_rY(i_id_rY), .i_id_rY_used(i_id_rY_used),
        .i_id_halt(i_id_halt), .i_ex_rO(i_ex_rO),
        .i_ex_dmem_ren(i_ex_dmem_ren), .i_ex_redirect(i_ex_redirect),
        .i_dmem_req(i_dmem_req), .i_dmem_ready(i_dmem_ready),
        .o_pc_wen(o_pc_wen), .o_ifid_wen(o_ifid_wen), .o_ifid_flush(o_ifid_flush),
        .o_idex_wen(o_idex_wen), .o_idex_flush(o_idex_flush),
        .o_exmem_wen(o_exmem_wen), .o_memwb_wen(o_memwb_wen),
        .o_halted(o_halted), .o_state(o_state),
        .o_stall_cycles(o_stall_cycles), .o_bubble_count(o_bubble_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [4:0] wen, input logic [1:0] fl,
                                input logic [1:0] st, input logic h);
        exp_t e;
        e = '0;
        e.chk = 1'b1; e.chk_fl = 1'b1;
        e.wen = wen; e.fl = fl; e.st = st; e.h = h;
        return e;
    endfunction

    function automatic exp_t perf(input exp_t ein, input logic [15:0] sc,
                                  input logic [15:0] bc);
        exp_t e;
        e = ein;
        e.chk_perf = 1'b1;
`ifdef HAZARD_PERF_EN
        e.sc = sc; e.bc = bc;
`else
        e.sc = 16'h0000; e.bc = 16'h0000;
        if (sc == bc) e.sc = 16'h0000;
`endif
        return e;
    endfunction

    // Expected control patterns
    exp_t E_IDLE, E_MST, E_REDIR, E_LUSE, E_HALT, E_DRAIN, E_DSTALL, E_HALTED, E_SKIP;
    stim_t S_IDLE;

    task automatic step(input stim_t s, input exp_t e, input string nm);
        @(posedge clk);
        #1;
        i_id_rX = s.rx; i_id_rX_used = s.rxu; i_id_rY = s.ry; i_id_rY_used = s.ryu;
        i_id_halt = s.halt; i_ex_rO = s.exro; i_ex_dmem_ren = s.ren;
        i_ex_redirect = s.redir; i_dmem_req = s.dreq; i_dmem_ready = s.drdy;
        rst = s.rst;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: outputs are valid every cycle; sample mid-cycle
    exp_t  m_e;
    string m_n;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            m_n = name_q.pop_front();
            if (m_e.chk) begin
                checks++;
                if ({o_pc_wen, o_ifid_wen, o_idex_wen, o_exmem_wen, o_memwb_wen} != m_e.wen) begin
                    errors++;
                    $display("FAIL %s wen: got %b want %b", m_n,
                             {o_pc_wen, o_ifid_wen, o_idex_wen, o_exmem_wen, o_memwb_wen}, m_e.wen);
                end
                if (m_e.chk_fl) begin
                    checks++;
                    if ({o_ifid_flush, o_idex_flush} != m_e.fl) begin
                        errors++;
                        $display("FAIL %s flush: got %b want %b", m_n,
                                 {o_ifid_flush, o_idex_flush}, m_e.fl);
                    end
                end
                checks++;
                if (o_state != m_e.st || o_halted != m_e.h) begin
                    errors++;
                    $display("FAIL %s state/halted: got %0d/%b want %0d/%b", m_n,
                             o_state, o_halted, m_e.st, m_e.h);
                end
                if (m_e.chk_perf) begin
                    checks++;
                    if (o_stall_cycles != m_e.sc || o_bubble_count != m_e.bc) begin
                        errors++;
                        $display("FAIL %s perf: got stall=%0d bubble=%0d want stall=%0d bubble=%0d",
                                 m_n, o_stall_cycles, o_bubble_count, m_e.sc, m_e.bc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        E_IDLE   = mk(5'b11111, 2'b00, 2'd0, 1'b0);
        E_MST    = mk(5'b00000, 2'b00, 2'd0, 1'b0);
        E_REDIR  = mk(5'b11111, 2'b11, 2'd0, 1'b0);
        E_LUSE   = mk(5'b00111, 2'b01, 2'd0, 1'b0);
        E_HALT   = mk(5'b01111, 2'b10, 2'd0, 1'b0);
        E_DRAIN  = mk(5'b01111, 2'b11, 2'd1, 1'b0);
        E_DSTALL = mk(5'b00000, 2'b00, 2'd1, 1'b0);
        E_DSTALL.chk_fl = 1'b0;
        E_HALTED = mk(5'b00000, 2'b00, 2'd2, 1'b1);
        E_SKIP   = '0;
        S_IDLE   = '0;

        i_id_rX = '0; i_id_rX_used = 1'b0; i_id_rY = '0; i_id_rY_used = 1'b0;
        i_id_halt = 1'b0; i_ex_rO = '0; i_ex_dmem_ren = 1'b0; i_ex_redirect = 1'b0;
        i_dmem_req = 1'b0; i_dmem_ready = 1'b0; rst = 1'b1;

        // Reset then idle
        s = S_IDLE; s.rst = 1'b1;
        step(s, E_SKIP, "rst");
        step(S_IDLE, perf(E_IDLE, 16'd0, 16'd0), "reset_idle");

        // Load-use hazards
        s = S_IDLE; s.rx = 3'd3; s.rxu = 1'b1; s.exro = 3'd3; s.ren = 1'b1;
        step(s, E_LUSE, "luse_rx");
        s.rxu = 1'b0;
        step(s, E_IDLE, "rx_unused");
        s = S_IDLE; s.rx = 3'd1; s.rxu = 1'b1; s.ry = 3'd5; s.ryu = 1'b1; s.exro = 3'd5; s.ren = 1'b1;
        step(s, E_LUSE, "luse_ry");
        s.exro = 3'd4;
        step(s, E_IDLE, "ro_mismatch");
        s.exro = 3'd5; s.ren = 1'b0;
        step(s, E_IDLE, "not_load");

        // Redirect beats load-use and halt
        s = S_IDLE; s.rx = 3'd2; s.rxu = 1'b1; s.exro = 3'd2; s.ren = 1'b1;
        s.halt = 1'b1; s.redir = 1'b1;
        step(s, E_REDIR, "redirect_prio");
        step(S_IDLE, E_IDLE, "after_redirect");

        // Load-use defers a halt in ID
        s = S_IDLE; s.rx = 3'd6; s.rxu = 1'b1; s.exro = 3'd6; s.ren = 1'b1; s.halt = 1'b1;
        step(s, E_LUSE, "luse_over_halt");

        // Memory stall for four cycles
        s = S_IDLE; s.rst = 1'b1;
        step(s, E_SKIP, "rst");
        s = S_IDLE; s.dreq = 1'b1; s.drdy = 1'b0;
        step(s, E_MST, "mstall_1");
        s.redir = 1'b1; s.halt = 1'b1;
        step(s, E_MST, "mstall_2");
        step(s, E_MST, "mstall_3");
        step(s, E_MST, "mstall_4");
        s = S_IDLE; s.dreq = 1'b1; s.drdy = 1'b1;
        step(s, perf(E_IDLE, 16'd4, 16'd0), "mstall_release");

        // Halt at cycle 10 with a stall at cycle 12
        s = S_IDLE; s.rst = 1'b1;
        step(s, E_SKIP, "rst");
        s = S_IDLE; s.halt = 1'b1;
        step(s, perf(E_HALT, 16'd0, 16'd0), "halt_c10");
        s = S_IDLE; s.halt = 1'b1; s.redir = 1'b1;
        step(s, E_DRAIN, "drain_c11");
        s = S_IDLE; s.dreq = 1'b1;
        step(s, E_DSTALL, "drain_stall_c12");
        s = S_IDLE; s.rx = 3'd1; s.rxu = 1'b1; s.exro = 3'd1; s.ren = 1'b1;
        step(s, E_DRAIN, "drain_c13");
        step(S_IDLE, E_DRAIN, "drain_c14");
        step(S_IDLE, perf(E_HALTED, 16'd5, 16'd3), "halted_c15");
        s = S_IDLE; s.halt = 1'b1; s.redir = 1'b1;
        step(s, perf(E_HALTED, 16'd5, 16'd3), "halted_c16");

        // Reset out of HALTED
        s = S_IDLE; s.rst = 1'b1;
        step(s, E_HALTED, "rst_in_halted");
        step(S_IDLE, perf(E_IDLE, 16'd0, 16'd0), "after_halted_rst");

        // Reset mid-drain at cycle 12
        s = S_IDLE; s.halt = 1'b1;
        step(s, E_HALT, "halt2_c10");
        step(S_IDLE, E_DRAIN, "drain2_c11");
        s = S_IDLE; s.rst = 1'b1;
        step(s, perf(E_DRAIN, 16'd2, 16'd1), "rst_in_drain_c12");
        step(S_IDLE, perf(E_IDLE, 16'd0, 16'd0), "after_drain_rst");

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctl.md
# hazard_ctl

Pipeline sequencing controller for the five-stage core. Each cycle it drives the write-enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Those controls resolve four conditions:
- load-use hazards,
- taken-branch redirects,
- data-memory stalls,
- orderly pipeline drain on `halt`.

It sits beside the decode stage and replaces the tied-high `write_en` on every pipeline flop.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 3: non-stalled cycles from halt leaving ID until the core reports halted; legal range 1..7.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `i_id_rX` in 3: source register X of the instruction in ID.
- `i_id_rX_used` in 1: ID instruction reads rX.
- `i_id_rY` in 3: source register Y of the instruction in ID.
- `i_id_rY_used` in 1: ID instruction reads rY.
- `i_id_halt` in 1: instruction in ID is halt.
- `i_ex_rO` in 3: destination register of the instruction in EX.
- `i_ex_dmem_ren` in 1: instruction in EX is a load.
- `i_ex_redirect` in 1: taken branch or jump resolved in EX.
- `i_dmem_req` in 1: MEM stage is accessing data memory.
- `i_dmem_ready` in 1: data memory completes the access this cycle.
- `o_pc_wen` out 1: PC register write enable.
- `o_ifid_wen` out 1: IF/ID write enable.
- `o_ifid_flush` out 1: IF/ID loads a bubble (all zero).
- `o_idex_wen` out 1: ID/EX write enable.
- `o_idex_flush` out 1: ID/EX loads a bubble.
- `o_exmem_wen` out 1: EX/MEM write enable.
- `o_memwb_wen` out 1: MEM/WB write enable.
- `o_halted` out 1: core has fully drained.
- `o_state` out 2: current state; RUN=0, DRAIN=1, HALTED=2.
- `o_stall_cycles` out 16: performance counter.
- `o_bubble_count` out 16: performance counter.

## Operation
A flush takes effect only when the matching write enable is 1. All control outputs are combinational from the current state and current inputs.

Internal conditions:
- `mstall` = `i_dmem_req & ~i_dmem_ready`.
- `luse` = `i_ex_dmem_ren & ((i_id_rX_used & i_id_rX==i_ex_rO) | (i_id_rY_used & i_id_rY==i_ex_rO))`.

RUN state, evaluated in priority order:
1. `mstall`: all five wen = 0, all flushes = 0. The whole pipe freezes, so the EX redirect and the ID halt inputs stay stable.
2. `i_ex_redirect`: all wen = 1, `o_ifid_flush` = 1, `o_idex_flush` = 1. A halt or load-use in ID is squashed and ignored.
3. `luse`: `o_pc_wen` = 0, `o_ifid_wen` = 0, `o_idex_flush` = 1, others wen = 1. The bubble lasts one cycle; a halt in ID is deferred to the next cycle.
4. `i_id_halt`: `o_pc_wen` = 0, `o_ifid_flush` = 1, others wen = 1. The halt is written into ID/EX. Next state is DRAIN and the counter loads `DRAIN_CYCLES`.
5. Otherwise all wen = 1 and all flushes = 0.

DRAIN state:
- `o_pc_wen` = 0, `o_ifid_flush` = 1, `o_idex_flush` = 1, all other wen = 1.
- `i_id_halt`, `i_ex_redirect` and `luse` are ignored.
- `mstall` freezes all wen to 0 and holds the counter.
- Each non-stalled cycle the counter decrements. When the counter is 1 on a non-stalled cycle, next state is HALTED.

HALTED state:
- All wen = 0, all flushes = 0, `o_halted` = 1.
- The state is terminal; only `rst` leaves it.

Reset:
- `rst` forces state to RUN, counter to 0, and both performance counters to 0.
- This applies in every state, including mid-DRAIN and HALTED.
- With idle inputs after reset: all wen = 1, flushes = 0, `o_halted` = 0, `o_state` = 0.

## Timing
- Inputs to control outputs: zero latency, same cycle.
- State, drain counter and performance counters update on the rising `clk` edge.
- Halt in ID at cycle T with no stalls gives:
  - DRAIN during cycles T+1 through T+`DRAIN_CYCLES`.
  - HALTED from cycle T+`DRAIN_CYCLES`+1.
  - With the default of 3, `o_halted` rises at T+4.
- Each stalled DRAIN cycle extends the drain by one cycle.
- A load-use bubble costs exactly one cycle; a redirect costs two squashed instructions.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `o_stall_cycles` increments on every cycle with `o_pc_wen` = 0 in RUN or DRAIN.
  - `o_bubble_count` increments on every cycle with `o_idex_flush` = 1 and `o_idex_wen` = 1.
  - Both counters saturate at 16'hFFFF and clear on `rst`.
- `HAZARD_PERF_EN` undefined: both ports are still present and tied to 16'h0000, and no counter logic is built.

## Test plan
- Reset, then idle inputs → all wen = 1, flushes = 0, `o_state` = 0, `o_halted` = 0.
- Load r3 in EX (`i_ex_rO` = 3, `i_ex_dmem_ren` = 1); ID reads rX = 3 → one cycle with `o_pc_wen` = 0, `o_ifid_wen` = 0, `o_idex_flush` = 1. With rX_used = 0 instead, the same inputs produce no stall.
- `i_ex_redirect` = 1 together with `luse` and `i_id_halt` → `o_ifid_flush` = 1, `o_idex_flush` = 1, `o_pc_wen` = 1, and `o_state` stays 0.
- `i_dmem_req` = 1 with `i_dmem_ready` = 0 for 4 cycles, then 1 → all wen = 0 for 4 cycles, then all 1; `o_stall_cycles` = 4 with `HAZARD_PERF_EN`.
- Halt in ID at cycle 10, stall asserted in cycle 12 → DRAIN for cycles 11–14, `o_halted` = 1 from cycle 15, and all wen remain 0 thereafter.
- `rst` pulsed during cycle 12 of the halt scenario → `o_state` = 0 and `o_halted` = 0 on the next cycle; with `HAZARD_PERF_EN`, both counters read 0.
